// File: rtl/fir_line_sequencer.sv
// fir_line_sequencer: per-line control FSM for the U/V chroma FIR upsampler.
// Optional `define FIR_SEQ_LINE_CLEAR_EN: pulse clear_SReg before every line (default: once per frame).
module fir_line_sequencer #(
    parameter int unsigned IMG_WIDTH  = 320,
    parameter int unsigned IMG_HEIGHT = 240,
    parameter logic [17:0] U_BASE     = 18'd38400,
    parameter logic [17:0] V_BASE     = 18'd57600
) (
    input  logic        CLOCK_50_I,
    input  logic        resetn,
    input  logic        start,
    output logic        done,
    output logic        busy,
    output logic [17:0] SRAM_address,
    output logic        SRAM_we_n,
    output logic        line_start,
    output logic        line_end,
    output logic        enable_U,
    output logic        enable_V,
    output logic        load_U_buffer,
    output logic        load_V_buffer,
    output logic        read_U_0,
    output logic        read_V_0,
    output logic        clear_SReg,
    output logic        cycle,
    output logic        pair_valid,
    output logic [7:0]  line_idx
);
    localparam int unsigned WPL = IMG_WIDTH / 4;
    localparam int unsigned SPL = IMG_WIDTH / 2;
    localparam int unsigned SW  = $clog2(SPL);
    localparam logic [17:0]   WPL_W     = 18'(WPL);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SPL - 1);
    localparam logic [SW-1:0] SLOT_TAIL = SW'(SPL - 3);
    localparam logic [7:0]    LINE_LAST = 8'(IMG_HEIGHT - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LEAD, S_COMMON, S_TAIL, S_DONE} state_t;

    state_t        state, state_n;
    logic [2:0]    cnt, cnt_n;
    logic [SW-1:0] slot, slot_n;
    logic [7:0]    line_n;
    logic [17:0]   line_base, line_base_n;
    logic          trail_n;
    logic [17:0]   word_n, addr_n;
    logic          rd_slot_n;
    logic          busy_n, done_n, ls_n, le_n, en_u_n, en_v_n, ld_u_n, ld_v_n;
    logic          rd_u0_n, rd_v0_n, clr_n, cyc_n, pv_n;

    // Outputs are decoded from the next-state values so every control is a flop.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        slot_n      = slot;
        line_n      = line_idx;
        line_base_n = line_base;
        trail_n     = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                state_n     = S_CLEAR;
                line_n      = '0;
                line_base_n = '0;
            end
            S_CLEAR: begin
                state_n = S_LEAD;
                cnt_n   = '0;
            end
            S_LEAD: if (cnt == 3'd7) begin
                state_n = S_COMMON;
                cnt_n   = '0;
                slot_n  = '0;
            end else begin
                cnt_n = cnt + 3'd1;
            end
            S_COMMON, S_TAIL: if (cnt == 3'd5) begin
                cnt_n = '0;
                if (slot == SLOT_LAST) begin
                    trail_n = 1'b1;
                    if (line_idx == LINE_LAST) begin
                        state_n = S_DONE;
                    end else begin
                        line_n      = line_idx + 8'd1;
                        line_base_n = line_base + WPL_W;
`ifdef FIR_SEQ_LINE_CLEAR_EN
                        state_n     = S_CLEAR;
`else
                        state_n     = S_LEAD;
`endif
                    end
                end else begin
                    slot_n = slot + SW'(1);
                    if (slot_n >= SLOT_TAIL) state_n = S_TAIL;
                end
            end else begin
                cnt_n = cnt + 3'd1;
            end
            // DONE: cnt 0 carries the trailing pair_valid, cnt 1 is the done pulse.
            S_DONE: if (cnt == 3'd0) cnt_n = 3'd1;
                    else             state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        word_n    = '0;
        rd_slot_n = 1'b0;
        addr_n    = '0;
        en_u_n    = 1'b0;
        en_v_n    = 1'b0;
        ld_u_n    = 1'b0;
        ld_v_n    = 1'b0;
        rd_u0_n   = 1'b0;
        rd_v0_n   = 1'b0;
        cyc_n     = 1'b0;
        pv_n      = trail_n;
        done_n    = (state_n == S_DONE) && (cnt_n == 3'd1);
        busy_n    = (state_n != S_IDLE) && !done_n;
        clr_n     = (state_n == S_CLEAR);
        ls_n      = (state_n == S_LEAD);
        le_n      = (state_n == S_TAIL);
        case (state_n)
            S_LEAD: begin
                rd_u0_n = (cnt_n == 3'd2);
                rd_v0_n = (cnt_n == 3'd3);
                en_u_n  = (cnt_n == 3'd4);
                en_v_n  = (cnt_n == 3'd5);
                ld_u_n  = (cnt_n == 3'd6);
                ld_v_n  = (cnt_n == 3'd7);
                if (cnt_n < 3'd6)
                    addr_n = (cnt_n[0] ? V_BASE : U_BASE) + line_base_n + 18'(cnt_n[2:1]);
            end
            S_COMMON, S_TAIL: begin
                word_n    = ((18'(slot_n) + 18'd1) >> 1) + 18'd2;
                rd_slot_n = (state_n == S_COMMON) && slot_n[0] && (word_n < WPL_W);
                en_u_n    = (cnt_n == 3'd2);
                en_v_n    = (cnt_n == 3'd5);
                ld_u_n    = rd_slot_n && (cnt_n == 3'd2);
                ld_v_n    = rd_slot_n && (cnt_n == 3'd5);
                cyc_n     = slot_n[0];
                pv_n      = trail_n || ((cnt_n == 3'd0) && (slot_n != '0));
                if (rd_slot_n && cnt_n == 3'd0)      addr_n = U_BASE + line_base_n + word_n;
                else if (rd_slot_n && cnt_n == 3'd3) addr_n = V_BASE + line_base_n + word_n;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            cnt           <= '0;
            slot          <= '0;
            line_idx      <= '0;
            line_base     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            SRAM_address  <= '0;
            line_start    <= 1'b0;
            line_end      <= 1'b0;
            enable_U      <= 1'b0;
            enable_V      <= 1'b0;
            load_U_buffer <= 1'b0;
            load_V_buffer <= 1'b0;
            read_U_0      <= 1'b0;
            read_V_0      <= 1'b0;
            clear_SReg    <= 1'b0;
            cycle         <= 1'b0;
            pair_valid    <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            slot          <= slot_n;
            line_idx      <= line_n;
            line_base     <= line_base_n;
            busy          <= busy_n;
            done          <= done_n;
            SRAM_address  <= addr_n;
            line_start    <= ls_n;
            line_end      <= le_n;
            enable_U      <= en_u_n;
            enable_V      <= en_v_n;
            load_U_buffer <= ld_u_n;
            load_V_buffer <= ld_v_n;
            read_U_0      <= rd_u0_n;
            read_V_0      <= rd_v0_n;
            clear_SReg    <= clr_n;
            cycle         <= cyc_n;
            pair_valid    <= pv_n;
        end
    end

    assign SRAM_we_n = 1'b1;

endmodule

// File: tb/tb_fir_line_sequencer.sv
// Bench for fir_line_sequencer: per-cycle trace against a frame schedule built from the line/slot rules.
// Frame height is reduced to keep runtime short; line width stays at 320.
module tb_fir_line_sequencer;
    localparam int unsigned W   = 320;
    localparam int unsigned H   = 8;
    localparam int unsigned WPL = W / 4;
    localparam int unsigned SPL = W / 2;
    localparam int unsigned UB  = 38400;
    localparam int unsigned VB  = 57600;
`ifdef FIR_SEQ_LINE_CLEAR_EN
    localparam bit CLR_EVERY = 1'b1;
`else
    localparam bit CLR_EVERY = 1'b0;
`endif

    logic        CLOCK_50_I = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        done, busy, SRAM_we_n;
    logic        line_start, line_end, enable_U, enable_V, load_U_buffer, load_V_buffer;
    logic        read_U_0, read_V_0, clear_SReg, cycle, pair_valid;
    logic [17:0] SRAM_address;
    logic [7:0]  line_idx;
    logic [12:0] obs_ctl;

    assign obs_ctl = {busy, done, line_start, line_end, enable_U, enable_V, load_U_buffer,
                      load_V_buffer, read_U_0, read_V_0, clear_SReg, cycle, pair_valid};

    fir_line_sequencer #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .U_BASE    (18'd38400),
        .V_BASE    (18'd57600)
    ) dut (
        .CLOCK_50_I   (CLOCK_50_I),
        .resetn       (resetn),
        .start        (start),
        .done         (done),
        .busy         (busy),
        .SRAM_address (SRAM_address),
        .SRAM_we_n    (SRAM_we_n),
        .line_start   (line_start),
        .line_end     (line_end),
        .enable_U     (enable_U),
        .enable_V     (enable_V),
        .load_U_buffer(load_U_buffer),
        .load_V_buffer(load_V_buffer),
        .read_U_0     (read_U_0),
        .read_V_0     (read_V_0),
        .clear_SReg   (clear_SReg),
        .cycle        (cycle),
        .pair_valid   (pair_valid),
        .line_idx     (line_idx)
    );

    always #10 CLOCK_50_I = ~CLOCK_50_I;

    typedef struct packed {
        logic busy, done, ls, le, enu, env, ldu, ldv, rdu0, rdv0, clr, cyc, pv;
        logic        av;
        logic [17:0] addr;
        logic        lchk;
        logic [7:0]  line;
        int          seg, ln, sl, k;   // seg: 0 clear, 1 lead, 2 slot, 3 trailing, 4 done, 5 idle
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [17:0] obs_lead[6];
    logic [17:0] obs_u1, obs_u153;
    int          obs_rdu0, obs_done, obs_clr, obs_pv, obs_le;

    function automatic exp_t blank(input int l, input int seg);
        exp_t e;
        e      = '0;
        e.busy = 1'b1;
        e.lchk = 1'b1;
        e.line = 8'(l);
        e.seg  = seg;
        e.ln   = l;
        return e;
    endfunction

    function automatic logic [12:0] pack_exp(input exp_t e);
        return {e.busy, e.done, e.ls, e.le, e.enu, e.env, e.ldu, e.ldv, e.rdu0, e.rdv0, e.clr, e.cyc, e.pv};
    endfunction

    // One entry per clock cycle from the cycle after start is sampled.
    function automatic void build_frame();
        exp_t e;
        bit   rd;
        exp_q.delete();
        for (int l = 0; l < int'(H); l++) begin
            if (l == 0 || CLR_EVERY) begin
                e = blank(l, 0); e.clr = 1'b1; e.pv = (l != 0);
                exp_q.push_back(e);
            end
            for (int c = 0; c < 8; c++) begin
                e = blank(l, 1); e.k = c; e.ls = 1'b1;
                e.pv   = (c == 0 && l != 0 && !CLR_EVERY);
                e.rdu0 = (c == 2); e.rdv0 = (c == 3);
                e.enu  = (c == 4); e.env  = (c == 5);
                e.ldu  = (c == 6); e.ldv  = (c == 7);
                if (c < 6) begin
                    e.av   = 1'b1;
                    e.addr = 18'(((c % 2 == 0) ? UB : VB) + l * WPL + c / 2);
                end
                exp_q.push_back(e);
            end
            for (int s = 0; s < int'(SPL); s++) begin
                for (int k = 0; k < 6; k++) begin
                    e = blank(l, 2); e.sl = s; e.k = k;
                    e.le  = (s >= int'(SPL) - 3);
                    e.enu = (k == 2);
                    e.env = (k == 5);
                    e.cyc = (s % 2 == 1);
                    e.pv  = (k == 0 && s > 0);
                    rd    = (s % 2 == 1) && ((s + 1) / 2 + 2 < int'(WPL)) && (s < int'(SPL) - 3);
                    e.ldu = rd && (k == 2);
                    e.ldv = rd && (k == 5);
                    if (rd && (k == 0 || k == 3)) begin
                        e.av   = 1'b1;
                        e.addr = 18'(((k == 0) ? UB : VB) + l * WPL + (s + 1) / 2 + 2);
                    end
                    exp_q.push_back(e);
                end
            end
        end
        e = blank(H - 1, 3); e.pv = 1'b1;
        exp_q.push_back(e);
        e = blank(H - 1, 4); e.busy = 1'b0; e.done = 1'b1;
        exp_q.push_back(e);
        for (int j = 0; j < 3; j++) begin
            e = blank(H - 1, 5); e.busy = 1'b0; e.lchk = 1'b0;
            exp_q.push_back(e);
        end
    endfunction

    task automatic reset_dut();
        resetn = 1'b0;
        start  = 1'b0;
        repeat (2) @(negedge CLOCK_50_I);
        resetn = 1'b1;
        @(negedge CLOCK_50_I);
    endtask

    // Pulses start, then compares every cycle against exp_q; returns early at stop_at.
    task automatic run_frame(input int n_pulses, input int stop_at);
        bit          pulse_mark[];
        int          sz;
        int          done_idx;
        exp_t        e;
        logic [12:0] exp_ctl;
        sz       = exp_q.size();
        done_idx = sz - 4;
        pulse_mark = new[sz];
        for (int p = 0; p < n_pulses; p++) pulse_mark[$urandom_range(done_idx, 0)] = 1'b1;
        if (n_pulses > 0) pulse_mark[done_idx] = 1'b1;
        obs_rdu0 = -1; obs_done = -1; obs_clr = 0; obs_pv = 0; obs_le = 0;
        obs_u1 = '0; obs_u153 = '0;
        for (int j = 0; j < 6; j++) obs_lead[j] = '0;
        @(negedge CLOCK_50_I); start = 1'b1;
        @(negedge CLOCK_50_I);
        for (int i = 0; i < sz; i++) begin
            start   = 1'b0;
            e       = exp_q[i];
            exp_ctl = pack_exp(e);
            n_cmp++;
            if (obs_ctl !== exp_ctl || SRAM_we_n !== 1'b1 || (e.lchk && line_idx !== e.line) ||
                (e.av && SRAM_address !== e.addr)) begin
                n_bad++;
                $display("FAIL trace[%0d] (seg %0d line %0d slot %0d k %0d): ctl=%b addr=%0d line_idx=%0d we_n=%b; expected ctl=%b addr=%0d (%0s) line_idx=%0d",
                         i, e.seg, e.ln, e.sl, e.k, obs_ctl, SRAM_address, line_idx, SRAM_we_n,
                         exp_ctl, e.addr, e.av ? "checked" : "unchecked", e.line);
                reset_dut();
                return;
            end
            if (e.seg == 1 && e.ln == 0 && e.k < 6) obs_lead[e.k] = SRAM_address;
            if (e.seg == 2 && e.ln == 0 && e.k == 0 && e.sl == 1)   obs_u1   = SRAM_address;
            if (e.seg == 2 && e.ln == 0 && e.k == 0 && e.sl == 153) obs_u153 = SRAM_address;
            if (read_U_0 === 1'b1 && obs_rdu0 < 0) obs_rdu0 = i;
            if (done === 1'b1 && obs_done < 0) obs_done = i;
            obs_clr += int'(clear_SReg);
            obs_pv  += int'(pair_valid);
            obs_le  += int'(line_end);
            if (i == stop_at) return;
            start = pulse_mark[i];
            @(negedge CLOCK_50_I);
        end
        start = 1'b0;
    endtask

    function automatic int done_index();
        return 1 + int'(H) * (1 + 8 + 6 * int'(SPL)) - (CLR_EVERY ? 0 : int'(H) - 1);
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge CLOCK_50_I);
        n_cmp++;
        if (obs_ctl !== '0 || SRAM_we_n !== 1'b1 || line_idx !== 8'd0 || SRAM_address !== 18'd0) begin
            n_bad++;
            $display("FAIL reset_values: ctl=%b we_n=%b line_idx=%0d addr=%0d, expected ctl=0 we_n=1 line_idx=0 addr=0",
                     obs_ctl, SRAM_we_n, line_idx, SRAM_address);
        end
        resetn = 1'b1;
        repeat ($urandom_range(6, 2)) @(negedge CLOCK_50_I);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_without_start: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_frame();
        logic [17:0] lead_ref[6];
        lead_ref = '{18'd38400, 18'd57600, 18'd38401, 18'd57601, 18'd38402, 18'd57602};
        build_frame();
        run_frame(0, -1);
        for (int j = 0; j < 6; j++) begin
            n_cmp++;
            if (obs_lead[j] !== lead_ref[j]) begin
                n_bad++;
                $display("FAIL lead_addr_c%0d: got %0d, expected %0d", j, obs_lead[j], lead_ref[j]);
            end
        end
        n_cmp++;
        if (obs_rdu0 !== 3) begin
            n_bad++;
            $display("FAIL read_U_0_cycle: got index %0d, expected 3 (LEAD c2)", obs_rdu0);
        end
        n_cmp++;
        if (obs_u1 !== 18'd38403) begin
            n_bad++;
            $display("FAIL u_addr_slot1: got %0d, expected 38403", obs_u1);
        end
        n_cmp++;
        if (obs_u153 !== 18'd38479) begin
            n_bad++;
            $display("FAIL u_addr_slot153: got %0d, expected 38479", obs_u153);
        end
        n_cmp++;
        if (obs_clr !== (CLR_EVERY ? int'(H) : 1)) begin
            n_bad++;
            $display("FAIL clear_SReg_count: got %0d, expected %0d", obs_clr, CLR_EVERY ? int'(H) : 1);
        end
        n_cmp++;
        if (obs_pv !== int'(H * SPL)) begin
            n_bad++;
            $display("FAIL pair_valid_count: got %0d, expected %0d", obs_pv, H * SPL);
        end
        n_cmp++;
        if (obs_le !== int'(H * 3 * 6)) begin
            n_bad++;
            $display("FAIL line_end_cycles: got %0d, expected %0d", obs_le, H * 18);
        end
        n_cmp++;
        if (obs_done !== done_index()) begin
            n_bad++;
            $display("FAIL done_cycle: got %0d, expected %0d", obs_done, done_index());
        end
    endtask

    task automatic test_back_to_back();
        build_frame();
        run_frame(int'($urandom_range(8, 3)), -1);
        n_cmp++;
        if (obs_done !== done_index()) begin
            n_bad++;
            $display("FAIL done_cycle_with_extra_starts: got %0d, expected %0d", obs_done, done_index());
        end
    endtask

    task automatic test_reset_midframe();
        int tgt;
        int kk;
        tgt = -1;
        kk  = int'($urandom_range(5, 0));
        build_frame();
        for (int i = 0; i < exp_q.size(); i++)
            if (tgt < 0 && exp_q[i].seg == 2 && exp_q[i].ln == 5 && exp_q[i].sl == 40 && exp_q[i].k == kk) tgt = i;
        run_frame(0, tgt);
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if (obs_ctl !== '0 || SRAM_we_n !== 1'b1 || line_idx !== 8'd0 || SRAM_address !== 18'd0) begin
            n_bad++;
            $display("FAIL async_reset_midframe: ctl=%b we_n=%b line_idx=%0d addr=%0d, expected ctl=0 we_n=1 line_idx=0 addr=0",
                     obs_ctl, SRAM_we_n, line_idx, SRAM_address);
        end
        repeat (2) @(negedge CLOCK_50_I);
        resetn = 1'b1;
        @(negedge CLOCK_50_I);
        build_frame();
        run_frame(2, -1);
        n_cmp++;
        if (obs_lead[0] !== 18'd38400) begin
            n_bad++;
            $display("FAIL restart_first_addr: got %0d, expected 38400", obs_lead[0]);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_back_to_back();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
